masked_share_encoder: RTL and testbench
=======================================

# masked_share_encoder

Input-side share generator for the masked half-adder datapath. Accepts plaintext bit pairs (A, B) over a valid/ready handshake and emits registered first-order Boolean shares (A0, A1, B0, B1) plus a fresh mask bit r0, all drawn from an internal LFSR PRNG. It sits upstream of the masked half-adder wrapper and drives its share and randomness inputs directly. A reseed port and a post-seed warm-up period ensure no output is produced from a freshly loaded PRNG state.

## Interface
- LFSR_W, 32: PRNG state width; fixed at 32.
- SEED, 32'hACE1_1234: LFSR value loaded at reset; must be nonzero.
- WARMUP, 16: LFSR advances after any seed load before input is accepted; range 1..255.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_seed_valid  in  1  load i_seed this cycle
- i_seed  in  32  new LFSR seed
- i_valid  in  1  plaintext pair present
- i_A  in  1  plaintext operand A
- i_B  in  1  plaintext operand B
- o_ready  out  1  encoder accepts i_A/i_B this cycle
- o_valid  out  1  share set valid
- i_ready  in  1  downstream consumes share set
- o_A0, o_A1, o_B0, o_B1  out  1 each  shares; o_A0^o_A1 = A, o_B0^o_B1 = B
- o_r0  out  1  fresh mask bit for the masked gadget

## Operation
- LFSR: Fibonacci form, polynomial x^32+x^22+x^2+x+1. One step: state <= {state[30:0], state[31]^state[21]^state[1]^state[0]}. One "advance" = 3 single steps, combinationally unrolled.
- Mask bits are taken from the current state before advancing: m_a = state[0], m_b = state[1], r = state[2].
- Encoding: o_A1 = m_a, o_A0 = A^m_a; o_B1 = m_b, o_B0 = B^m_b; o_r0 = r.
- FSM states: WARM, RUN.
  - WARM: 8-bit counter loaded with WARMUP; the LFSR advances every cycle and the counter decrements; o_ready = 0; at 0 -> RUN.
  - RUN: o_ready = !o_valid || i_ready. On accept (i_valid && o_ready), the share set is registered and the LFSR advances once. The LFSR holds when there is no accept.
- Seed load: i_seed_valid in any state loads the LFSR (i_seed, or 32'h0000_0001 if i_seed == 0), reloads the counter, and moves the FSM to WARM. A seed load takes priority over any advance in the same cycle.
- Simultaneous accept and seed in RUN: the input is accepted using the current pre-seed LFSR bits; the seed then overwrites the LFSR.
- Output register: one entry. It holds its value while o_valid && !i_ready. It drains normally during WARM; reseeding never drops or alters a pending set.

## Timing
- Reset (rst_n = 0): LFSR = SEED, FSM = WARM, counter = WARMUP, o_valid = 0, o_ready = 0, all share outputs 0.
- After reset release or any seed load, o_ready rises exactly WARMUP cycles later.
- Latency: accept at edge N gives o_valid = 1 with the shares at edge N+1.
- Throughput: 1 set/cycle while i_ready = 1.
- Reset asserted mid-transfer: pending output is discarded and o_valid drops immediately (asynchronous).
- Outputs are driven from flops only; no combinational path from i_A/i_B to outputs. o_ready depends combinationally only on state, o_valid, and i_ready.

## Structure
- Package masked_share_pkg:
  - LFSR_W, tap positions, ZERO_SEED_SUB = 32'h1
  - FSM state enum {WARM, RUN}
  - function lfsr_step and function lfsr_advance (3 steps)
- Sub-module share_lfsr: holds state, with seed load, advance enable, and a 3-bit mask output. The top level contains the FSM, counter, and output register.

## Test plan
- Reset with defaults, i_valid = 1 held -> o_ready = 0 for 16 cycles, then 1; the first set's mask bits equal bits [2:0] of SEED advanced 16 times, per the package model.
- Stream all four (A, B) pairs with i_ready = 1 -> o_valid 1 cycle after each accept; o_A0^o_A1 = A and o_B0^o_B1 = B for every set; masks match the model LFSR advanced once per accept.
- Backpressure: i_ready = 0 for 5 cycles with o_valid = 1 -> outputs stable, o_ready = 0, LFSR unchanged; release -> the next set uses the next advance.
- Seed 32'h0 -> behaves identically to seed 32'h1; o_ready low for exactly 16 cycles.
- Seed and accept in the same RUN cycle -> the accepted set uses pre-seed masks, the FSM enters WARM, and the pending output drains while in WARM.
- Assert rst_n mid-stream with o_valid = 1 -> o_valid = 0 and all outputs 0 immediately; after release, the first set matches the reset-from-SEED sequence.

Source files
------------

// File: rtl/masked_share_pkg.sv
// Shared types and PRNG helpers for the masked share encoder.
package masked_share_pkg;

  localparam int LFSR_W = 32;
  localparam int TAP_A  = 31;
  localparam int TAP_B  = 21;
  localparam int TAP_C  = 1;
  localparam int TAP_D  = 0;
  localparam int ADV_STEPS = 3;
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

  typedef enum logic {WARM, RUN} enc_state_e;

  // Fibonacci step for x^32+x^22+x^2+x+1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  // Three steps per advance so every consumed mask triple is fresh state.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] t;
    t = s;
    for (int i = 0; i < ADV_STEPS; i++) t = lfsr_step(t);
    return t;
  endfunction

endpackage

// File: rtl/share_lfsr.sv
// PRNG state holder: reseed has priority over advance; mask is pre-advance state.
module share_lfsr
  import masked_share_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_1234
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [2:0]        mask
);

  logic [LFSR_W-1:0] st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         st_q <= SEED;
    else if (seed_load) st_q <= (seed == '0) ? ZERO_SEED_SUB : seed;
    else if (adv)       st_q <= lfsr_advance(st_q);
  end

  assign mask = st_q[2:0];

endmodule

// File: rtl/masked_share_encoder.sv
// Plaintext (A,B) -> registered first-order Boolean shares plus fresh mask r0,
// with a warm-up period after every PRNG seed before input is accepted.
module masked_share_encoder #(
  parameter int          LFSR_W = 32,
  parameter logic [31:0] SEED   = 32'hACE1_1234,
  parameter int          WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_seed_valid,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_valid,
  input  logic              i_A,
  input  logic              i_B,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_A0,
  output logic              o_A1,
  output logic              o_B0,
  output logic              o_B1,
  output logic              o_r0
);
  import masked_share_pkg::*;

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  enc_state_e state_q, state_d;
  logic [7:0] cnt_q;
  logic [2:0] mask;
  logic       accept, adv;

  share_lfsr #(.SEED(SEED)) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (i_seed_valid),
    .seed      (i_seed),
    .adv       (adv),
    .mask      (mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WARM;
    else        state_q <= state_d;
  end

  // Leave WARM on the edge that consumes the last warm-up advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WARM:    if (cnt_q == 8'd1) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = WARM;
    endcase
    if (i_seed_valid) state_d = WARM;
  end

  always_comb begin
    o_ready = (state_q == RUN) && (!o_valid || i_ready);
    accept  = i_valid && o_ready;
    adv     = (state_q == WARM) || accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= WARM_INIT;
    else if (i_seed_valid)      cnt_q <= WARM_INIT;
    else if (state_q == WARM)   cnt_q <= cnt_q - 8'd1;
  end

  // Single-entry output stage; independent of reseed so a pending set always drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_A0    <= 1'b0;
      o_A1    <= 1'b0;
      o_B0    <= 1'b0;
      o_B1    <= 1'b0;
      o_r0    <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_A0    <= i_A ^ mask[0];
      o_A1    <= mask[0];
      o_B0    <= i_B ^ mask[1];
      o_B1    <= mask[1];
      o_r0    <= mask[2];
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_masked_share_encoder.sv
// Randomized self-checking bench for masked_share_encoder against a PRNG/share model.
module tb_masked_share_encoder;

  localparam logic [31:0] SEED = 32'hACE1_1234;
  localparam int WARMUP = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_seed_valid = 1'b0;
  logic [31:0] i_seed = '0;
  logic i_valid = 1'b0, i_A = 1'b0, i_B = 1'b0, i_ready = 1'b0;
  logic o_ready, o_valid, o_A0, o_A1, o_B0, o_B1, o_r0;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] m;

  always #5 clk = ~clk;

  masked_share_encoder #(.LFSR_W(32), .SEED(SEED), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst_n(rst_n), .i_seed_valid(i_seed_valid), .i_seed(i_seed),
    .i_valid(i_valid), .i_A(i_A), .i_B(i_B), .o_ready(o_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_A0(o_A0), .o_A1(o_A1), .o_B0(o_B0), .o_B1(o_B1), .o_r0(o_r0)
  );

  wire [4:0] act = {o_A0, o_A1, o_B0, o_B1, o_r0};

  function automatic logic [31:0] ref_advance(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    repeat (3) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    return t;
  endfunction

  function automatic logic [31:0] ref_warm(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    repeat (WARMUP) t = ref_advance(t);
    return t;
  endfunction

  // Share set for plaintext (a,b) under PRNG state s: {A0,A1,B0,B1,r0}.
  function automatic logic [4:0] ref_set(input logic a, input logic b, input logic [31:0] s);
    return {a ^ s[0], s[0], b ^ s[1], s[1], s[2]};
  endfunction

  task automatic test_reset;
    int n;
    logic a, b;
    rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    #12;
    vec_cnt++;
    if ({o_valid, o_ready, act} !== 7'b0) begin
      err_cnt++; $display("FAIL reset_state got=%b want=0000000", {o_valid, o_ready, act});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    while (!o_ready && n < 100) begin @(posedge clk); n++; #1; end
    vec_cnt++;
    if (n != WARMUP) begin err_cnt++; $display("FAIL reset_warmup got=%0d want=%0d", n, WARMUP); end
    m = ref_warm(SEED);
    a = 1'($urandom); b = 1'($urandom);
    i_A = a; i_B = b;
    @(posedge clk); #1;
    vec_cnt++;
    if (!o_valid || act !== ref_set(a, b, m)) begin
      err_cnt++; $display("FAIL reset_first_set got=%b/%b want=1/%b", o_valid, act, ref_set(a, b, m));
    end
    m = ref_advance(m);
    i_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    logic a, b;
    i_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      a = (k < 4) ? k[0] : 1'($urandom);
      b = (k < 4) ? k[1] : 1'($urandom);
      i_valid = 1'b1; i_A = a; i_B = b;
      vec_cnt++;
      if (o_ready !== 1'b1) begin err_cnt++; $display("FAIL stream_ready k=%0d got=%b want=1", k, o_ready); end
      @(posedge clk); #1;
      vec_cnt++;
      if (!o_valid || act !== ref_set(a, b, m) || (o_A0 ^ o_A1) !== a || (o_B0 ^ o_B1) !== b) begin
        err_cnt++; $display("FAIL stream_set k=%0d got=%b/%b want=1/%b", k, o_valid, act, ref_set(a, b, m));
      end
      m = ref_advance(m);
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_drain got=%b want=0", o_valid); end
  endtask

  task automatic test_backpressure;
    logic a, b;
    logic [4:0] held;
    i_ready = 1'b0;
    a = 1'($urandom); b = 1'($urandom);
    i_valid = 1'b1; i_A = a; i_B = b;
    @(posedge clk); #1;
    held = ref_set(a, b, m);
    m = ref_advance(m);
    vec_cnt++;
    if (!o_valid || act !== held) begin
      err_cnt++; $display("FAIL bp_first got=%b/%b want=1/%b", o_valid, act, held);
    end
    for (int c = 0; c < 5; c++) begin
      i_A = 1'($urandom); i_B = 1'($urandom);
      vec_cnt++;
      if (o_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ready c=%0d got=%b want=0", c, o_ready); end
      @(posedge clk); #1;
      vec_cnt++;
      if (!o_valid || act !== held) begin
        err_cnt++; $display("FAIL bp_hold c=%0d got=%b/%b want=1/%b", c, o_valid, act, held);
      end
    end
    a = 1'($urandom); b = 1'($urandom);
    i_A = a; i_B = b; i_ready = 1'b1;
    #1;
    vec_cnt++;
    if (o_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready got=%b want=1", o_ready); end
    @(posedge clk); #1;
    vec_cnt++;
    if (!o_valid || act !== ref_set(a, b, m)) begin
      err_cnt++; $display("FAIL bp_next_set got=%b/%b want=1/%b", o_valid, act, ref_set(a, b, m));
    end
    m = ref_advance(m);
    i_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_seed;
    int n;
    logic a, b;
    for (int s = 0; s < 2; s++) begin
      i_valid = 1'b0; i_ready = 1'b1;
      i_seed_valid = 1'b1; i_seed = 32'(s);
      @(posedge clk); #1;
      i_seed_valid = 1'b0;
      n = 0;
      while (!o_ready && n < 100) begin @(posedge clk); n++; #1; end
      vec_cnt++;
      if (n != WARMUP) begin err_cnt++; $display("FAIL seed%0d_warmup got=%0d want=%0d", s, n, WARMUP); end
      m = ref_warm(32'h1);
      for (int k = 0; k < 3; k++) begin
        a = 1'($urandom); b = 1'($urandom);
        i_valid = 1'b1; i_A = a; i_B = b;
        @(posedge clk); #1;
        vec_cnt++;
        if (!o_valid || act !== ref_set(a, b, m)) begin
          err_cnt++; $display("FAIL seed%0d_set k=%0d got=%b/%b want=1/%b", s, k, o_valid, act, ref_set(a, b, m));
        end
        m = ref_advance(m);
      end
      i_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_seed_accept;
    int n;
    logic a, b;
    logic [31:0] s;
    logic [4:0] held;
    s = $urandom | 32'h1;
    a = 1'($urandom); b = 1'($urandom);
    i_ready = 1'b0; i_valid = 1'b1; i_A = a; i_B = b;
    i_seed_valid = 1'b1; i_seed = s;
    @(posedge clk); #1;
    i_seed_valid = 1'b0; i_valid = 1'b0;
    held = ref_set(a, b, m);
    n = 0;
    vec_cnt++;
    if (!o_valid || act !== held || o_ready !== 1'b0) begin
      err_cnt++; $display("FAIL sa_pre_seed got=%b/%b/%b want=1/%b/0", o_valid, act, o_ready, held);
    end
    @(posedge clk); n++; #1;
    vec_cnt++;
    if (!o_valid || act !== held) begin
      err_cnt++; $display("FAIL sa_hold_warm got=%b/%b want=1/%b", o_valid, act, held);
    end
    i_ready = 1'b1;
    @(posedge clk); n++; #1;
    vec_cnt++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      err_cnt++; $display("FAIL sa_drain_warm got=%b%b want=00", o_valid, o_ready);
    end
    while (!o_ready && n < 100) begin @(posedge clk); n++; #1; end
    vec_cnt++;
    if (n != WARMUP) begin err_cnt++; $display("FAIL sa_warmup got=%0d want=%0d", n, WARMUP); end
    m = ref_warm(s);
    a = 1'($urandom); b = 1'($urandom);
    i_valid = 1'b1; i_A = a; i_B = b;
    @(posedge clk); #1;
    vec_cnt++;
    if (!o_valid || act !== ref_set(a, b, m)) begin
      err_cnt++; $display("FAIL sa_post_seed got=%b/%b want=1/%b", o_valid, act, ref_set(a, b, m));
    end
    m = ref_advance(m);
    i_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    logic a, b;
    i_ready = 1'b0;
    a = 1'($urandom); b = 1'($urandom);
    i_valid = 1'b1; i_A = a; i_B = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    vec_cnt++;
    if (o_valid !== 1'b1) begin err_cnt++; $display("FAIL rm_pending got=%b want=1", o_valid); end
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({o_valid, o_ready, act} !== 7'b0) begin
      err_cnt++; $display("FAIL rm_async_clear got=%b want=0000000", {o_valid, o_ready, act});
    end
    @(posedge clk); #1 rst_n = 1'b1; i_ready = 1'b1;
    n = 0;
    while (!o_ready && n < 100) begin @(posedge clk); n++; #1; end
    vec_cnt++;
    if (n != WARMUP) begin err_cnt++; $display("FAIL rm_warmup got=%0d want=%0d", n, WARMUP); end
    m = ref_warm(SEED);
    for (int k = 0; k < 2; k++) begin
      a = 1'($urandom); b = 1'($urandom);
      i_valid = 1'b1; i_A = a; i_B = b;
      @(posedge clk); #1;
      vec_cnt++;
      if (!o_valid || act !== ref_set(a, b, m)) begin
        err_cnt++; $display("FAIL rm_set k=%0d got=%b/%b want=1/%b", k, o_valid, act, ref_set(a, b, m));
      end
      m = ref_advance(m);
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_seed();
    test_seed_accept();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
